player_input_conditioner: RTL
=============================

// Module: player_input_conditioner
// PURPOSE
//  Upstream of the player object. Turns the four raw, bouncy direction buttons into clean
//  one-cycle, one-hot move requests on slowClk, one request per move.
//  Stages: 2-flop synchroniser -> debounce FSM -> optional auto-repeat -> priority arbitration.
//  Output btns[3:0] feeds the player rectangle's button input directly.
// PARAMETERS
//  DEBOUNCE_CYCLES  16'd20000  consecutive stable slowClk samples required to accept a level change
//  REPEAT_DELAY     24'd300000 cycles from the press pulse to the first repeat pulse (AUTOREPEAT_EN only)
//  REPEAT_PERIOD    24'd150000 cycles between subsequent repeat pulses (AUTOREPEAT_EN only)
// PORTS
//  slowClk        in   1  system clock for this block
//  rst            in   1  synchronous, active-high reset
//  btns_raw       in   4  raw pushbuttons, asynchronous: [0]=up [1]=down [2]=left [3]=right
//  playerDisable  in   1  1 = suppress all move pulses; FSMs keep tracking
//  btns           out  4  one-hot move pulse, high for exactly 1 cycle, same bit mapping as btns_raw
//  move_valid     out  1  OR of btns, same cycle
//  btn_level      out  4  debounced button levels
//  move_conflict  out  1  1-cycle pulse: >=2 candidate pulses in one cycle, lower-priority ones dropped
// BEHAVIOUR
//  Reset: all outputs 0; synchronisers 0; every FSM enters IDLE; all counters 0. rst wins over all inputs.
//  Synchroniser: per bit, 2 flops; only sync2 is used downstream.
//  Per-button FSM states and transitions:
//   - IDLE: sync2=1 -> PRESS_DB with cnt=0.
//   - PRESS_DB: count while sync2=1; sync2=0 -> IDLE, cnt=0.
//     cnt==DEBOUNCE_CYCLES-1 -> HELD; level:=1; emit a candidate pulse.
//   - HELD: sync2=0 -> RELEASE_DB, cnt=0. Otherwise run the repeat timer (AUTOREPEAT_EN only).
//   - RELEASE_DB: count while sync2=0; sync2=1 -> HELD, repeat timer is not reset.
//     cnt==DEBOUNCE_CYCLES-1 -> IDLE; level:=0; no pulse.
//  Latency: btns bit rises on the (DEBOUNCE_CYCLES+3)rd rising edge after btns_raw is first sampled high
//   (2 sync + DEBOUNCE_CYCLES + 1 output register). Release produces no output event.
//  Glitches: a glitch shorter than DEBOUNCE_CYCLES restarts the count; no pulse, level unchanged.
//  Arbitration, registered:
//   - Fixed priority up>down>left>right; exactly one btns bit wins.
//   - Losers are dropped, never queued; move_conflict=1 in the same cycle as the winner.
//  playerDisable=1: btns, move_valid and move_conflict are forced 0. FSMs, levels and repeat timers keep running.
//   Pulses suppressed while disabled are lost; deasserting playerDisable does not replay them.
//  Counters saturate and never wrap. Repeat timer width is 24 bits; its compare uses ==.
//  Mid-operation rst clears every state on the next edge; a held button must re-debounce from IDLE.
// CONFIGURATION
//  AUTOREPEAT_EN defined:
//   - While in HELD, a candidate pulse occurs REPEAT_DELAY cycles after the press pulse,
//     then every REPEAT_PERIOD cycles.
//   - Timer is cleared on entry to IDLE; it is held, not advanced, during RELEASE_DB.
//  AUTOREPEAT_EN undefined:
//   - Exactly one pulse per debounced press; repeat timers and REPEAT_* logic are absent.
// STRUCTURE
//  Shared package game_input_pkg holds:
//   - DIR_UP=0, DIR_DOWN=1, DIR_LEFT=2, DIR_RIGHT=3
//   - 2-bit FSM encoding: IDLE=0, PRESS_DB=1, HELD=2, RELEASE_DB=3
//  Sub-module btn_debounce_fsm holds sync, FSM, counters and repeat timer for one button; instantiated 4 times.
//  The top level holds only the arbiter and the output registers.
// TESTING  (sim params: DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=4)
//  1. btns_raw=4'b0001 held from edge 0 -> btns=4'b0001 for one cycle at edge 7; btn_level[0]=1 from edge 7.
//  2. btns_raw[2] high 3 cycles then low -> btns stays 0 and btn_level stays 0 throughout.
//  3. btns_raw=4'b1010 rising in the same cycle -> btns=4'b0010 once; move_conflict=1 in that cycle.
//  4. AUTOREPEAT_EN, up held 40 cycles -> pulses at edges 7, 15, 19, 23 ... spaced 4.
//     Without the macro -> only the edge-7 pulse.
//  5. playerDisable=1 during the edge-7 pulse -> btns=0. Deassert at edge 10 -> btns stays 0; btn_level[0]=1.
//  6. rst at edge 9 while right is held -> all outputs 0 at edge 10; next pulse at edge 17 (re-debounced).

Source files
------------

// File: rtl/game_input_pkg.sv
// Shared types for the player input path: direction indices and debounce FSM states.
// Used by btn_debounce_fsm and player_input_conditioner.
package game_input_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        PRESS_DB   = 2'd1,
        HELD       = 2'd2,
        RELEASE_DB = 2'd3
    } btnState_t;

endpackage

// File: rtl/btn_debounce_fsm.sv
// One button: 2-flop synchroniser, debounce FSM and, with AUTOREPEAT_EN, a repeat timer.
// Emits a registered one-cycle candidate pulse per accepted press (and per repeat).
module btn_debounce_fsm
    import game_input_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd20000
`ifdef AUTOREPEAT_EN
   ,parameter logic [23:0] REPEAT_DELAY  = 24'd300000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd150000
`endif
) (
    input  logic slowClk,
    input  logic rst,
    input  logic btnRaw,
    output logic level,
    output logic pulse
);

    logic sync1, sync2;
    btnState_t state, stateNext;
    logic [15:0] cnt, cntNext;
    logic levelNext, pulseNext;
    logic cntDone;

`ifdef AUTOREPEAT_EN
    logic [23:0] timer, timerNext, limit;
    logic repeating, repeatingNext;
`endif

    assign cntDone = (cnt == DEBOUNCE_CYCLES - 16'd1);

    always_ff @(posedge slowClk) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
            pulse <= 1'b0;
`ifdef AUTOREPEAT_EN
            timer     <= '0;
            repeating <= 1'b0;
`endif
        end else begin
            sync1 <= btnRaw;
            sync2 <= sync1;
            state <= stateNext;
            cnt   <= cntNext;
            level <= levelNext;
            pulse <= pulseNext;
`ifdef AUTOREPEAT_EN
            timer     <= timerNext;
            repeating <= repeatingNext;
`endif
        end
    end

    always_comb begin
        stateNext = state;
        cntNext   = cnt;
        levelNext = level;
        pulseNext = 1'b0;
`ifdef AUTOREPEAT_EN
        timerNext     = timer;
        repeatingNext = repeating;
        limit         = repeating ? REPEAT_PERIOD : REPEAT_DELAY;
`endif
        unique case (state)
            IDLE: begin
                if (sync2) begin
                    stateNext = PRESS_DB;
                    cntNext   = '0;
                end
            end
            PRESS_DB: begin
                if (!sync2) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                end else if (cntDone) begin
                    stateNext = HELD;
                    cntNext   = '0;
                    levelNext = 1'b1;
                    pulseNext = 1'b1;
                end else if (cnt != '1) begin
                    cntNext = cnt + 16'd1;
                end
            end
            HELD: begin
                if (!sync2) begin
                    stateNext = RELEASE_DB;
                    cntNext   = '0;
                end else begin
`ifdef AUTOREPEAT_EN
                    if (timer == limit - 24'd1) begin
                        pulseNext     = 1'b1;
                        timerNext     = '0;
                        repeatingNext = 1'b1;
                    end else if (timer != '1) begin
                        timerNext = timer + 24'd1;
                    end
`endif
                end
            end
            RELEASE_DB: begin
                // a bounce back high resumes HELD with the repeat timer untouched
                if (sync2) begin
                    stateNext = HELD;
                    cntNext   = '0;
                end else if (cntDone) begin
                    stateNext = IDLE;
                    cntNext   = '0;
                    levelNext = 1'b0;
                end else if (cnt != '1) begin
                    cntNext = cnt + 16'd1;
                end
            end
            default: stateNext = IDLE;
        endcase
`ifdef AUTOREPEAT_EN
        if (stateNext == IDLE) begin
            timerNext     = '0;
            repeatingNext = 1'b0;
        end
`endif
    end

endmodule

// File: rtl/player_input_conditioner.sv
// Four debounced buttons into a registered fixed-priority one-hot move pulse.
// Optional feature macro: AUTOREPEAT_EN (auto-repeat while a button is held).
module player_input_conditioner
    import game_input_pkg::*;
#(
    parameter logic [15:0] DEBOUNCE_CYCLES = 16'd20000
`ifdef AUTOREPEAT_EN
   ,parameter logic [23:0] REPEAT_DELAY  = 24'd300000,
    parameter logic [23:0] REPEAT_PERIOD = 24'd150000
`endif
) (
    input  logic       slowClk,
    input  logic       rst,
    input  logic [3:0] btns_raw,
    input  logic       playerDisable,
    output logic [3:0] btns,
    output logic       move_valid,
    output logic [3:0] btn_level,
    output logic       move_conflict
);

    logic [3:0] cand, levels, winner;
    logic conflict;

    for (genvar i = 0; i < 4; i++) begin : gBtn
        btn_debounce_fsm #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef AUTOREPEAT_EN
           ,.REPEAT_DELAY (REPEAT_DELAY),
            .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
        ) uFsm (
            .slowClk(slowClk),
            .rst    (rst),
            .btnRaw (btns_raw[i]),
            .level  (levels[i]),
            .pulse  (cand[i])
        );
    end

    always_comb begin
        winner = '0;
        priority case (1'b1)
            cand[DIR_UP]:    winner[DIR_UP]    = 1'b1;
            cand[DIR_DOWN]:  winner[DIR_DOWN]  = 1'b1;
            cand[DIR_LEFT]:  winner[DIR_LEFT]  = 1'b1;
            cand[DIR_RIGHT]: winner[DIR_RIGHT] = 1'b1;
            default: ;
        endcase
    end

    // more than one bit set
    assign conflict = |(cand & (cand - 4'd1));

    always_ff @(posedge slowClk) begin
        if (rst) begin
            btns          <= '0;
            move_valid    <= 1'b0;
            btn_level     <= '0;
            move_conflict <= 1'b0;
        end else begin
            btns          <= playerDisable ? 4'd0 : winner;
            move_valid    <= !playerDisable && (|cand);
            btn_level     <= levels;
            move_conflict <= !playerDisable && conflict;
        end
    end

endmodule
